spi_word_scheduler: RTL and testbench
=====================================

SPI_WORD_SCHEDULER -- requirements
Module: spi_word_scheduler

Interface
REQ-001 Parameters: NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameters: CS_SETUP_CLKS, default 2, i_Clk cycles from CS assertion to TX launch (>=1).
REQ-003 Parameters: CS_HOLD_CLKS, default 2, i_Clk cycles from frame completion to CS release (>=1).
REQ-004 Parameters: START_TIMEOUT, default 8, max i_Clk cycles waiting for the master to drop ready after launch (>=2).
REQ-005 One clock and asynchronous active-low reset. Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_L  input  1  reset; asynchronous, active-low.
- i_Req_DV  input  NUM_REQ  per-requester word valid, level, held until ack.
- i_Req_Word  input  12*NUM_REQ  packed words; requester k at [12k+11:12k].
- o_Req_Ack  output  NUM_REQ  one-hot, one-cycle accept pulse.
- o_TX_Byte  output  12  word to SPI master.
- o_TX_DV  output  1  one-cycle launch pulse to SPI master.
- i_TX_Ready  input  1  SPI master idle (high = idle/ready).
- o_SPI_CS_n  output  NUM_REQ  per-slave chip select, active-low, at most one low.
- o_Busy  output  1  high in every state except IDLE.
- o_Err  output  1  one-cycle pulse on start timeout.

Function
REQ-006 The block SHALL implement FSM states IDLE, SETUP, LAUNCH, WAIT_START, WAIT_DONE, HOLD; all outputs registered.
REQ-007 IDLE: if any i_Req_DV bit high and i_TX_Ready high, grant the round-robin winner k; else stay in IDLE.
REQ-008 Round-robin: search starts at (last_grant+1) mod NUM_REQ, ascending with wrap; last_grant updates only on grant.
REQ-009 Cycle after grant: o_Req_Ack[k]=1 for exactly one cycle, o_TX_Byte = i_Req_Word[k] sampled at grant edge, o_SPI_CS_n[k]=0, state SETUP.
REQ-010 o_TX_Byte SHALL hold the latched word unchanged from ack until return to IDLE.
REQ-011 SETUP lasts exactly CS_SETUP_CLKS cycles, then LAUNCH.
REQ-012 LAUNCH lasts one cycle with o_TX_DV=1; then WAIT_START with timeout counter cleared.
REQ-013 WAIT_START: on i_TX_Ready low go WAIT_DONE; if START_TIMEOUT cycles elapse with ready high, pulse o_Err one cycle and go HOLD.
REQ-014 WAIT_DONE: on i_TX_Ready high go HOLD; no timeout.
REQ-015 HOLD lasts exactly CS_HOLD_CLKS cycles with CS still low; then all o_SPI_CS_n high, state IDLE.
REQ-016 Minimum CS-high gap between consecutive frames SHALL be one cycle (the IDLE cycle); no back-to-back grant from HOLD.
REQ-017 i_Req_DV is ignored outside IDLE; a requester dropping DV before grant is not granted; DV changes after grant do not affect the frame.
REQ-018 Simultaneous requests: exactly one grant per frame; non-winners keep waiting without ack.
REQ-019 i_TX_Ready low in IDLE blocks all grants (master busy externally).
REQ-020 o_SPI_CS_n bits other than the granted one SHALL stay high in all states.

Reset
REQ-021 On i_Rst_L low, immediately: state IDLE, o_SPI_CS_n all ones, o_TX_DV=0, o_Req_Ack=0, o_Err=0, o_Busy=0, o_TX_Byte=12'h000, counters 0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-022 Reset mid-frame SHALL abort without ack/DV glitches; the interrupted requester is not acked again unless it re-requests after reset release.

Verification
REQ-023 Single request: DV[2]=1, word 12'hA5C, ready high -> ack[2] next cycle, CS_n[2] low, DV pulse 2 cycles after ack, o_TX_Byte=12'hA5C.
REQ-024 All 4 requesting continuously from reset -> grant order 0,1,2,3,0; each ack one cycle; never two CS low.
REQ-025 Master model drops ready 1 cycle after DV, raises 24 SPI edges later -> CS held 2 cycles after ready high, then 1 cycle all-high before next CS.
REQ-026 Master never drops ready -> o_Err pulse exactly 8 cycles after DV, HOLD 2 cycles, CS released, next grant proceeds.
REQ-027 Reset asserted in WAIT_DONE -> CS all high, o_Busy=0 same cycle; after release DV[0] alone granted first.
REQ-028 i_TX_Ready held low with DV[1]=1 -> no ack; ready rises -> ack[1] next cycle.

Source files
------------

// File: rtl/spi_word_scheduler.sv
// Purpose: round-robin arbiter that frames one 12-bit word per grant onto a shared SPI master with per-slave CS.
// Latency: ack 1 cycle after grant edge, TX launch CS_SETUP_CLKS cycles after ack, CS released CS_HOLD_CLKS after done.
// Backpressure: grants only in IDLE with i_TX_Ready high; requesters hold DV until ack, losers simply keep waiting.
module spi_word_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_REQ-1:0]      i_Req_DV,
  input  logic [12*NUM_REQ-1:0]   i_Req_Word,
  output logic [NUM_REQ-1:0]      o_Req_Ack,
  output logic [11:0]             o_TX_Byte,
  output logic                    o_TX_DV,
  input  logic                    i_TX_Ready,
  output logic [NUM_REQ-1:0]      o_SPI_CS_n,
  output logic                    o_Busy,
  output logic                    o_Err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 16;

  // Terminal counts; the start timeout fires one cycle early in the counter so the
  // error pulse lands START_TIMEOUT cycles after the launch pulse (launch cycle counts).
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CLKS - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CLKS - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(START_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last_grant;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [11:0]     win_word;

  // Round-robin pick: first requester found after the previous winner, wrapping.
  always_comb begin
    int cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      if (!win_vld && i_Req_DV[cand]) begin
        win_vld = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  // Select the winner's word so it can be latched on the grant edge.
  always_comb begin
    win_word = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_idx == IW'(j)) win_word = i_Req_Word[12*j +: 12];
    end
  end

  // Frame sequencer; every output is a register so nothing glitches toward the slaves.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      o_Req_Ack  <= '0;
      o_TX_Byte  <= 12'h000;
      o_TX_DV    <= 1'b0;
      o_SPI_CS_n <= '1;
      o_Busy     <= 1'b0;
      o_Err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // i_TX_Ready low here means the master is busy for someone else.
          if (win_vld && i_TX_Ready) begin
            state               <= S_SETUP;
            cnt                 <= '0;
            last_grant          <= win_idx;
            o_Req_Ack[win_idx]  <= 1'b1;
            o_TX_Byte           <= win_word;
            o_SPI_CS_n[win_idx] <= 1'b0;
            o_Busy              <= 1'b1;
          end
        end
        S_SETUP: begin
          o_Req_Ack <= '0;
          if (cnt == SETUP_LAST) begin
            state   <= S_LAUNCH;
            cnt     <= '0;
            o_TX_DV <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LAUNCH: begin
          o_TX_DV <= 1'b0;
          cnt     <= '0;
          state   <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (!i_TX_Ready) begin
            state <= S_WAIT_DONE;
          end else if (cnt == TMO_LAST) begin
            // Master never picked up the word: flag it and close the frame anyway.
            o_Err <= 1'b1;
            cnt   <= '0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (i_TX_Ready) begin
            cnt   <= '0;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          o_Err <= 1'b0;
          if (cnt == HOLD_LAST) begin
            // Going to IDLE (not straight to a new grant) guarantees a CS-high cycle.
            o_SPI_CS_n <= '1;
            o_Busy     <= 1'b0;
            cnt        <= '0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          o_SPI_CS_n <= '1;
          o_Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_scheduler.sv
// Purpose: directed self-checking bench for spi_word_scheduler with default parameters.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: i_TX_Ready is driven by hand to emulate the SPI master.
module tb_spi_word_scheduler;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic [3:0]  i_Req_DV;
  logic [47:0] i_Req_Word;
  logic [3:0]  o_Req_Ack;
  logic [11:0] o_TX_Byte;
  logic        o_TX_DV;
  logic        i_TX_Ready;
  logic [3:0]  o_SPI_CS_n;
  logic        o_Busy;
  logic        o_Err;

  int n_checks = 0;
  int n_pass   = 0;
  int mon_bad  = 0;
  logic [3:0] prev_ack = 4'h0;
  logic [11:0] words [4] = '{12'h111, 12'h222, 12'hA5C, 12'h3C3};

  spi_word_scheduler dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Req_DV   (i_Req_DV),
    .i_Req_Word (i_Req_Word),
    .o_Req_Ack  (o_Req_Ack),
    .o_TX_Byte  (o_TX_Byte),
    .o_TX_DV    (o_TX_DV),
    .i_TX_Ready (i_TX_Ready),
    .o_SPI_CS_n (o_SPI_CS_n),
    .o_Busy     (o_Busy),
    .o_Err      (o_Err)
  );

  always #5 i_Clk = ~i_Clk;

  // Continuous invariants: at most one CS low, acks one-hot and never two cycles in a row.
  always @(negedge i_Clk) begin
    if ($countones(~o_SPI_CS_n) > 1) mon_bad++;
    if ($countones(o_Req_Ack) > 1) mon_bad++;
    if (o_Req_Ack != 4'h0 && prev_ack != 4'h0) mon_bad++;
    prev_ack = o_Req_Ack;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  // Advance until an ack appears or the budget runs out (then got stays 0).
  task automatic wait_ack(output logic [3:0] got);
    int n = 0;
    tick();
    while (o_Req_Ack == 4'h0 && n < 40) begin
      tick();
      n++;
    end
    got = o_Req_Ack;
  endtask

  initial begin
    int bad;
    logic [3:0] got;
    i_Rst_L    = 1'b0;
    i_Req_DV   = 4'h0;
    i_TX_Ready = 1'b1;
    i_Req_Word = {words[3], words[2], words[1], words[0]};
    @(negedge i_Clk);
    @(negedge i_Clk);

    // Reset state
    chk("rst_cs",   o_SPI_CS_n, 4'hF);
    chk("rst_dv",   o_TX_DV,    1'b0);
    chk("rst_ack",  o_Req_Ack,  4'h0);
    chk("rst_err",  o_Err,      1'b0);
    chk("rst_busy", o_Busy,     1'b0);
    chk("rst_byte", o_TX_Byte,  12'h000);

    // Single request on requester 2, normal master handshake
    i_Rst_L  = 1'b1;
    i_Req_DV = 4'b0100;
    tick();
    chk("s_ack",  o_Req_Ack,  4'b0100);
    chk("s_cs",   o_SPI_CS_n, 4'b1011);
    chk("s_byte", o_TX_Byte,  12'hA5C);
    chk("s_busy", o_Busy,     1'b1);
    i_Req_DV = 4'h0;
    tick();
    chk("s_ack_once", o_Req_Ack, 4'h0);
    chk("s_dv_early", o_TX_DV,   1'b0);
    tick();
    chk("s_dv", o_TX_DV, 1'b1);
    i_TX_Ready = 1'b0;
    tick();
    chk("s_dv_pulse", o_TX_DV, 1'b0);
    i_Req_DV = 4'b1000;  // must be ignored mid-frame
    bad = 0;
    repeat (24) begin
      tick();
      if (o_Req_Ack != 4'h0 || o_SPI_CS_n != 4'b1011 || o_TX_Byte != 12'hA5C) bad++;
    end
    chk("s_xfer_stable", bad, 0);
    i_TX_Ready = 1'b1;
    tick();
    chk("s_hold1_cs", o_SPI_CS_n, 4'b1011);
    tick();
    chk("s_hold2_cs", o_SPI_CS_n, 4'b1011);
    chk("s_hold_byte", o_TX_Byte, 12'hA5C);
    tick();
    chk("s_gap_cs",   o_SPI_CS_n, 4'hF);
    chk("s_gap_busy", o_Busy,     1'b0);
    chk("s_gap_ack",  o_Req_Ack,  4'h0);

    // Requester 3 granted right after the gap; master never starts -> timeout
    tick();
    chk("t_ack",  o_Req_Ack,  4'b1000);
    chk("t_cs",   o_SPI_CS_n, 4'b0111);
    chk("t_byte", o_TX_Byte,  12'h3C3);
    i_Req_DV = 4'h0;
    tick();
    tick();
    chk("t_dv", o_TX_DV, 1'b1);
    bad = 0;
    repeat (7) begin
      tick();
      if (o_Err) bad++;
    end
    chk("t_err_early", bad, 0);
    tick();
    chk("t_err",    o_Err,      1'b1);
    chk("t_err_cs", o_SPI_CS_n, 4'b0111);
    tick();
    chk("t_err_pulse", o_Err,      1'b0);
    chk("t_hold2_cs",  o_SPI_CS_n, 4'b0111);
    tick();
    chk("t_rel_cs",   o_SPI_CS_n, 4'hF);
    chk("t_rel_busy", o_Busy,     1'b0);

    // All four requesting from reset: order 0,1,2,3,0
    i_Rst_L = 1'b0;
    tick();
    i_Rst_L  = 1'b1;
    i_Req_DV = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_ack(got);
      chk("rr_ack",  got,       32'(1) << (g % 4));
      chk("rr_byte", o_TX_Byte, words[g % 4]);
    end
    i_Req_DV = 4'h0;
    begin
      int n = 0;
      while (o_Busy && n < 40) begin
        tick();
        n++;
      end
    end
    chk("rr_idle", o_Busy, 1'b0);

    // Reset while waiting for the master to finish
    i_Req_DV = 4'b0010;
    tick();
    chk("r_ack", o_Req_Ack, 4'b0010);
    i_Req_DV = 4'h0;
    tick();
    tick();
    chk("r_dv", o_TX_DV, 1'b1);
    i_TX_Ready = 1'b0;
    tick();
    tick();
    chk("r_cs_pre",   o_SPI_CS_n, 4'b1101);
    chk("r_busy_pre", o_Busy,     1'b1);
    #2 i_Rst_L = 1'b0;
    #1;
    chk("r_cs",   o_SPI_CS_n, 4'hF);
    chk("r_busy", o_Busy,     1'b0);
    chk("r_ack0", o_Req_Ack,  4'h0);
    chk("r_dv0",  o_TX_DV,    1'b0);
    @(negedge i_Clk);
    i_Rst_L    = 1'b1;
    i_TX_Ready = 1'b1;
    i_Req_DV   = 4'b0001;
    tick();
    chk("r_regrant", o_Req_Ack,  4'b0001);
    chk("r_regr_cs", o_SPI_CS_n, 4'b1110);

    // Master busy in IDLE blocks the grant until ready rises
    i_Rst_L = 1'b0;
    tick();
    i_Rst_L    = 1'b1;
    i_TX_Ready = 1'b0;
    i_Req_DV   = 4'b0010;
    bad = 0;
    repeat (3) begin
      tick();
      if (o_Req_Ack != 4'h0 || o_Busy || o_SPI_CS_n != 4'hF) bad++;
    end
    chk("b_blocked", bad, 0);
    i_TX_Ready = 1'b1;
    tick();
    chk("b_ack",  o_Req_Ack,  4'b0010);
    chk("b_cs",   o_SPI_CS_n, 4'b1101);
    chk("b_byte", o_TX_Byte,  12'h222);

    chk("mon_invariants", mon_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
